// File: rtl/pad_gpio_pkg.sv
// ============================================================================
// Module      : pad_gpio_pkg
// Description : Shared types and default constants for the GPIO pad
//               front-end (interrupt edge-type encoding, default widths).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pad_gpio_pkg;

    // Per-pad interrupt edge selection, two bits per pad on irq_type_i.
    typedef enum logic [1:0] {
        IRQ_NONE = 2'b00,
        IRQ_RISE = 2'b01,
        IRQ_FALL = 2'b10,
        IRQ_BOTH = 2'b11
    } irq_type_e;

    localparam int c_num_pads_dflt   = 32;
    localparam int c_debounce_w_dflt = 8;

endpackage : pad_gpio_pkg

`default_nettype wire

// File: rtl/pad_gpio_filter.sv
// ============================================================================
// Module      : pad_gpio_filter
// Description : One pad's input conditioning: two-flop synchronizer,
//               optional debounce filter, edge detector and sticky
//               interrupt status bit.
// Macro       : GPIO_DEBOUNCE_EN - when defined the counter-based glitch
//               filter is built and debounce_thr_i exists; otherwise the
//               filtered level simply follows the synchronizer output.
// Ports       : clk_i, rst_i     clock / sync active-high reset
//               pad_in_i         raw asynchronous pad level
//               debounce_thr_i   filter threshold (filter builds only)
//               irq_type_i       edge selection (irq_type_e encoding)
//               irq_clr_i        single-cycle clear of the status bit
//               level_o          filtered, synchronized pad level
//               status_o         sticky edge status
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pad_gpio_filter
    import pad_gpio_pkg::*;
#(
    parameter int DebounceW = c_debounce_w_dflt
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 pad_in_i,
`ifdef GPIO_DEBOUNCE_EN
    input  logic [DebounceW-1:0] debounce_thr_i,
`endif
    input  logic [1:0]           irq_type_i,
    input  logic                 irq_clr_i,
    output logic                 level_o,
    output logic                 status_o
);

    logic      r_sync1;
    logic      r_sync2;
    logic      r_stable;
    logic      r_stable_d;
    logic      r_status;
    irq_type_e w_type;
    logic      w_rise;
    logic      w_fall;
    logic      w_event;

    // Two-flop synchronizer for the asynchronous pad level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pad_in_i;
            r_sync2 <= r_sync1;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    logic [DebounceW-1:0] r_cnt;

    // The new level is accepted only after the synchronized input has
    // disagreed with the accepted level for thr+1 consecutive cycles.
    // Any agreement in between restarts the count, so cnt never exceeds
    // the threshold and cannot wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (r_sync2 == r_stable) begin
            r_cnt    <= '0;
        end else if (r_cnt >= debounce_thr_i) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
        end else begin
            r_cnt    <= r_cnt + 1'b1;
        end
    end
`else
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stable <= 1'b0;
        end else begin
            r_stable <= r_sync2;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stable_d <= 1'b0;
        end else begin
            r_stable_d <= r_stable;
        end
    end

    assign w_type  = irq_type_e'(irq_type_i);
    assign w_rise  = r_stable & ~r_stable_d;
    assign w_fall  = ~r_stable & r_stable_d;
    assign w_event = (w_rise && (w_type == IRQ_RISE || w_type == IRQ_BOTH)) ||
                     (w_fall && (w_type == IRQ_FALL || w_type == IRQ_BOTH));

    // Set has priority over clear so an event coinciding with a software
    // clear is never lost.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_status <= 1'b0;
        end else if (w_event) begin
            r_status <= 1'b1;
        end else if (irq_clr_i) begin
            r_status <= 1'b0;
        end
    end

    assign level_o  = r_stable;
    assign status_o = r_status;

endmodule : pad_gpio_filter

`default_nettype wire

// File: rtl/pad_gpio_frontend.sv
// ============================================================================
// Module      : pad_gpio_frontend
// Description : GPIO front-end between the core GPIO registers and the pad
//               IOBUF cells. Registers the output/enable path, and per pad
//               instantiates an input filter with edge-interrupt status.
// Macro       : GPIO_DEBOUNCE_EN - enables the per-pad debounce counters;
//               when undefined debounce_thr_i is ignored.
// Ports       : clk_i, rst_i     clock / sync active-high reset
//               gpio_out_i       data to drive on each pad
//               gpio_dir_i       1 = pad is output
//               pad_out_o        to pad I
//               pad_oen_o        to pad OEN (1 = tristate)
//               pad_in_i         from pad O (asynchronous)
//               gpio_in_o        filtered, synchronized pad level
//               debounce_thr_i   shared filter threshold
//               irq_type_i       2 bits per pad edge selection
//               irq_clr_i        per-pad status clear
//               irq_status_o     sticky edge status
//               irq_o            OR of all status bits
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pad_gpio_frontend
    import pad_gpio_pkg::*;
#(
    parameter int NumPads   = c_num_pads_dflt,
    parameter int DebounceW = c_debounce_w_dflt
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NumPads-1:0]     gpio_out_i,
    input  logic [NumPads-1:0]     gpio_dir_i,
    output logic [NumPads-1:0]     pad_out_o,
    output logic [NumPads-1:0]     pad_oen_o,
    input  logic [NumPads-1:0]     pad_in_i,
    output logic [NumPads-1:0]     gpio_in_o,
    input  logic [DebounceW-1:0]   debounce_thr_i,
    input  logic [2*NumPads-1:0]   irq_type_i,
    input  logic [NumPads-1:0]     irq_clr_i,
    output logic [NumPads-1:0]     irq_status_o,
    output logic                   irq_o
);

    logic [NumPads-1:0] r_pad_out;
    logic [NumPads-1:0] r_pad_oen;
    logic [NumPads-1:0] w_level;
    logic [NumPads-1:0] w_status;

    // Output path is a plain register stage; reset leaves every pad tristated.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pad_out <= '0;
            r_pad_oen <= '1;
        end else begin
            r_pad_out <= gpio_out_i;
            r_pad_oen <= ~gpio_dir_i;
        end
    end

    // Input sampling runs regardless of direction so output loopback is
    // visible on gpio_in_o.
    for (genvar k = 0; k < NumPads; k++) begin : g_pad
        pad_gpio_filter #(
            .DebounceW      (DebounceW)
        ) u_filter (
            .clk_i          (clk_i),
            .rst_i          (rst_i),
            .pad_in_i       (pad_in_i[k]),
`ifdef GPIO_DEBOUNCE_EN
            .debounce_thr_i (debounce_thr_i),
`endif
            .irq_type_i     (irq_type_i[2*k +: 2]),
            .irq_clr_i      (irq_clr_i[k]),
            .level_o        (w_level[k]),
            .status_o       (w_status[k])
        );
    end : g_pad

`ifndef GPIO_DEBOUNCE_EN
    // Threshold has no consumer without the filter.
    logic w_unused_thr;
    assign w_unused_thr = ^debounce_thr_i;
`endif

    assign pad_out_o    = r_pad_out;
    assign pad_oen_o    = r_pad_oen;
    assign gpio_in_o    = w_level;
    assign irq_status_o = w_status;
    assign irq_o        = |w_status;

endmodule : pad_gpio_frontend

`default_nettype wire

// File: tb/tb_pad_gpio_frontend.sv
// ============================================================================
// Module      : tb_pad_gpio_frontend
// Description : Directed self-checking bench for pad_gpio_frontend. Expected
//               latencies follow GPIO_DEBOUNCE_EN (filter: 2+thr, else 2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pad_gpio_frontend;

    localparam int NP = 32;
    localparam int DW = 8;

`ifdef GPIO_DEBOUNCE_EN
    localparam bit c_filt = 1'b1;
`else
    localparam bit c_filt = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [NP-1:0]   gpio_out, gpio_dir, pad_out, pad_oen, pad_in, gpio_in;
    logic [DW-1:0]   thr;
    logic [2*NP-1:0] irq_type;
    logic [NP-1:0]   irq_clr, irq_status;
    logic            irq;

    int checks   = 0;
    int failures = 0;
    int lat;

    pad_gpio_frontend #(.NumPads(NP), .DebounceW(DW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .gpio_out_i     (gpio_out),
        .gpio_dir_i     (gpio_dir),
        .pad_out_o      (pad_out),
        .pad_oen_o      (pad_oen),
        .pad_in_i       (pad_in),
        .gpio_in_o      (gpio_in),
        .debounce_thr_i (thr),
        .irq_type_i     (irq_type),
        .irq_clr_i      (irq_clr),
        .irq_status_o   (irq_status),
        .irq_o          (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_clr(input int pad);
        irq_clr[pad] = 1'b1;
        tick();
        irq_clr[pad] = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        gpio_out = '0;
        gpio_dir = '0;
        pad_in   = '0;
        thr      = 8'd4;
        irq_type = '0;
        irq_clr  = '0;
        lat      = c_filt ? 2 + 4 : 2;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_oen",    64'(pad_oen),    64'hFFFF_FFFF);
        check("rst_out",    64'(pad_out),    64'h0);
        check("rst_irq",    64'(irq),        64'h0);
        check("rst_gpioin", 64'(gpio_in),    64'h0);
        check("rst_status", 64'(irq_status), 64'h0);
        rst = 1'b0;
        tick();

        // ---------------- output path ----------------
        gpio_dir = 32'h0000_00F0;
        gpio_out = 32'h0000_00A0;
        #1;
        check("oen_before_edge", 64'(pad_oen), 64'hFFFF_FFFF);
        tick();
        check("oen_after", 64'(pad_oen), 64'hFFFF_FF0F);
        check("out_after", 64'(pad_out), 64'h0000_00A0);

        // ---------------- debounce pass, pad 3 rising ----------------
        irq_type[7:6] = 2'b01;
        pad_in[3] = 1'b1;
        for (int k = 0; k <= lat + 1; k++) begin
            tick();
            check($sformatf("pass_gpio3_E%0d", k), 64'(gpio_in[3]), 64'(k >= lat));
            check($sformatf("pass_stat3_E%0d", k), 64'(irq_status[3]), 64'(k >= lat + 1));
        end
        check("pass_irq", 64'(irq), 64'h1);

        // falling edge with rise-only type leaves status set
        pad_in[3] = 1'b0;
        for (int k = 0; k < lat + 3; k++) tick();
        check("fall3_gpio", 64'(gpio_in[3]), 64'h0);
        check("fall3_stat", 64'(irq_status[3]), 64'h1);
        pulse_clr(3);
        check("clr3_stat", 64'(irq_status[3]), 64'h0);
        check("clr3_irq",  64'(irq), 64'h0);

        // ---------------- glitch: pad 3 high for 3 cycles ----------------
        pad_in[3] = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            tick();
            if (k == 2) pad_in[3] = 1'b0;
            check($sformatf("glitch_gpio3_E%0d", k), 64'(gpio_in[3]),
                  64'(!c_filt && k >= 2 && k <= 4));
            check($sformatf("glitch_stat3_E%0d", k), 64'(irq_status[3]),
                  64'(!c_filt && k >= 3));
        end
        pulse_clr(3);
        check("glitch_clr3", 64'(irq_status[3]), 64'h0);

        // ---------------- edge types on pad 5 ----------------
        irq_type[11:10] = 2'b10;
        pad_in[5] = 1'b1;
        for (int k = 0; k < lat + 3; k++) tick();
        check("fallonly_rise_gpio", 64'(gpio_in[5]), 64'h1);
        check("fallonly_rise_stat", 64'(irq_status[5]), 64'h0);
        pad_in[5] = 1'b0;
        for (int k = 0; k < lat + 3; k++) tick();
        check("fallonly_fall_gpio", 64'(gpio_in[5]), 64'h0);
        check("fallonly_fall_stat", 64'(irq_status[5]), 64'h1);
        pulse_clr(5);
        check("fallonly_clr", 64'(irq_status[5]), 64'h0);

        irq_type[11:10] = 2'b00;
        pad_in[5] = 1'b1;
        for (int k = 0; k < lat + 3; k++) tick();
        check("none_rise_stat", 64'(irq_status[5]), 64'h0);
        pad_in[5] = 1'b0;
        for (int k = 0; k < lat + 3; k++) tick();
        check("none_fall_stat", 64'(irq_status[5]), 64'h0);

        // ---------------- set/clear collision ----------------
        irq_type[11:10] = 2'b11;
        pad_in[5] = 1'b1;
        for (int k = 0; k <= lat; k++) tick();
        check("coll_pre_stat", 64'(irq_status[5]), 64'h0);
        pulse_clr(5);
        check("coll_set_wins", 64'(irq_status[5]), 64'h1);
        check("coll_irq",      64'(irq), 64'h1);
        pulse_clr(5);
        check("coll_clr_alone", 64'(irq_status[5]), 64'h0);
        check("coll_irq_low",   64'(irq), 64'h0);

        // ---------------- pad 7 with maximum threshold ----------------
        thr = 8'hFF;
        lat = c_filt ? 2 + 255 : 2;
        pad_in[7] = 1'b1;
        for (int k = 0; k < lat; k++) tick();
        check("p7_before", 64'(gpio_in[7]), 64'h0);
        tick();
        check("p7_after", 64'(gpio_in[7]), 64'h1);
        check("p7_stat",  64'(irq_status[7]), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pad_gpio_frontend

`default_nettype wire
